// File: rtl/video_out_stage_if.sv
// Pixel, timing and measurement bundle between the test-pattern generator
// side and the video mixer side of video_out_stage.
interface video_out_stage_if #(
    parameter int CNT_W = 11
);
    logic             ce_pix;
    logic [7:0]       video;
    logic             HBlank;
    logic             VBlank;
    logic             HSync;
    logic             VSync;
    logic [1:0]       scanlines;
    logic [1:0]       tint;
    logic             ce_pix_o;
    logic [7:0]       r;
    logic [7:0]       g;
    logic [7:0]       b;
    logic             de;
    logic             hs_o;
    logic             vs_o;
    logic             hb_o;
    logic             vb_o;
    logic [CNT_W-1:0] act_width;
    logic [CNT_W-1:0] act_height;
    logic             meas_stb;

    modport slave (
        input  ce_pix, video, HBlank, VBlank, HSync, VSync, scanlines, tint,
        output ce_pix_o, r, g, b, de, hs_o, vs_o, hb_o, vb_o,
        output act_width, act_height, meas_stb
    );

    modport master (
        output ce_pix, video, HBlank, VBlank, HSync, VSync, scanlines, tint,
        input  ce_pix_o, r, g, b, de, hs_o, vs_o, hb_o, vb_o,
        input  act_width, act_height, meas_stb
    );
endinterface

// File: rtl/video_out_stage.sv
// Two-stage luma to RGB post-processor: scanline dimming, colour tint,
// sync alignment and active frame geometry measurement.
module video_out_stage #(
    parameter int CNT_W = 11,
    parameter int PIPE  = 2
) (
    input logic               clk,
    input logic               reset,
    video_out_stage_if.slave  vid
);
    localparam logic [CNT_W-1:0] CMAX = '1;

    if (PIPE != 2) begin : g_pipe_chk
        $error("video_out_stage only supports PIPE = 2");
    end

    logic [7:0]       v1;
    logic             hb1;
    logic             vb1;
    logic             hs1;
    logic             vs1;
    logic             de1;
    logic             de1_d;
    logic             vb1_d;
    logic             odd;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic [CNT_W-1:0] last_w;
    logic             fall;
    logic             vrise;
    logic [7:0]       dim;
    logic [7:0]       tr;
    logic [7:0]       tg;
    logic [7:0]       tb;
    logic [CNT_W-1:0] w_fin;
    logic [CNT_W-1:0] h_fin;

    assign fall  = de1_d & ~de1;
    assign vrise = vb1 & ~vb1_d;

    // A line ending on the same pixel that VBlank rises still belongs to this frame
    assign w_fin = fall ? hcnt : last_w;
    assign h_fin = (fall && vcnt != CMAX) ? vcnt + 1'b1 : vcnt;

    always_comb begin
        dim = v1;
        if (odd) begin
            case (vid.scanlines)
                2'd1:    dim = v1 - (v1 >> 2);
                2'd2:    dim = v1 >> 1;
                2'd3:    dim = v1 >> 2;
                default: dim = v1;
            endcase
        end
    end

    always_comb begin
        tr = 8'd0;
        tg = 8'd0;
        tb = 8'd0;
        case (vid.tint)
            2'd0: begin
                tr = dim;
                tg = dim;
                tb = dim;
            end
            2'd1: tg = dim;
            2'd2: begin
                tr = dim;
                tg = (dim >> 1) + (dim >> 2);
            end
            default: begin
                tg = dim >> 1;
                tb = dim;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1           <= 8'd0;
            hb1          <= 1'b0;
            vb1          <= 1'b0;
            hs1          <= 1'b0;
            vs1          <= 1'b0;
            de1          <= 1'b0;
            de1_d        <= 1'b0;
            vb1_d        <= 1'b0;
            odd          <= 1'b0;
            vid.ce_pix_o <= 1'b0;
            vid.r        <= 8'd0;
            vid.g        <= 8'd0;
            vid.b        <= 8'd0;
            vid.de       <= 1'b0;
            vid.hs_o     <= 1'b0;
            vid.vs_o     <= 1'b0;
            vid.hb_o     <= 1'b0;
            vid.vb_o     <= 1'b0;
        end else begin
            vid.ce_pix_o <= vid.ce_pix;
            if (vid.ce_pix) begin
                v1    <= vid.video;
                hb1   <= vid.HBlank;
                vb1   <= vid.VBlank;
                hs1   <= vid.HSync;
                vs1   <= vid.VSync;
                de1   <= ~vid.HBlank & ~vid.VBlank;
                de1_d <= de1;
                vb1_d <= vb1;
                if (vb1) begin
                    odd <= 1'b0;
                end else if (fall) begin
                    odd <= ~odd;
                end
                vid.r    <= de1 ? tr : 8'd0;
                vid.g    <= de1 ? tg : 8'd0;
                vid.b    <= de1 ? tb : 8'd0;
                vid.de   <= de1;
                vid.hs_o <= hs1;
                vid.vs_o <= vs1;
                vid.hb_o <= hb1;
                vid.vb_o <= vb1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt           <= '0;
            vcnt           <= '0;
            last_w         <= '0;
            vid.act_width  <= '0;
            vid.act_height <= '0;
            vid.meas_stb   <= 1'b0;
        end else begin
            vid.meas_stb <= 1'b0;
            if (vid.ce_pix) begin
                if (vrise) begin
                    vid.act_width  <= w_fin;
                    vid.act_height <= h_fin;
                    vid.meas_stb   <= 1'b1;
                    hcnt           <= '0;
                    vcnt           <= '0;
                    last_w         <= '0;
                end else if (fall) begin
                    last_w <= hcnt;
                    hcnt   <= '0;
                    if (vcnt != CMAX) begin
                        vcnt <= vcnt + 1'b1;
                    end
                end else if (de1 && hcnt != CMAX) begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_video_out_stage.sv
// Randomised bench for video_out_stage: a pixel-level frame model predicts
// every output each clock, and literal checks pin key values.
module tb_video_out_stage;
    localparam int CNT_W = 11;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;

    video_out_stage_if #(.CNT_W(CNT_W)) vid ();

    video_out_stage #(.CNT_W(CNT_W), .PIPE(2)) dut (
        .clk   (clk),
        .reset (reset),
        .vid   (vid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] h_v = 8'd0;
    logic h_de = 0, h_hs = 0, h_vs = 0, h_hb = 0, h_vb = 0, h_odd = 0;
    logic p_de = 0, p_vb = 0;
    int   line_idx = 0, run = 0, nlines = 0, lastw = 0;
    logic pend = 0;
    int   pend_w = 0, pend_h = 0;
    logic [7:0] e_r = 0, e_g = 0, e_b = 0;
    logic e_de = 0, e_hs = 0, e_vs = 0, e_hb = 0, e_vb = 0, e_ce = 0, e_stb = 0;
    int   e_aw = 0, e_ah = 0;

    function automatic logic [23:0] pixel(input logic [7:0] v, input logic dark,
                                          input logic [1:0] sl, input logic [1:0] tn);
        logic [7:0] d;
        d = v;
        if (dark) begin
            if (sl == 2'd1) d = v - v / 8'd4;
            else if (sl == 2'd2) d = v / 8'd2;
            else if (sl == 2'd3) d = v / 8'd4;
        end
        case (tn)
            2'd0:    pixel = {d, d, d};
            2'd1:    pixel = {8'd0, d, 8'd0};
            2'd2:    pixel = {d, 8'(d / 8'd2 + d / 8'd4), 8'd0};
            default: pixel = {8'd0, 8'(d / 8'd2), d};
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        logic xde;
        if (reset) begin
            h_v = 0; h_de = 0; h_hs = 0; h_vs = 0; h_hb = 0; h_vb = 0; h_odd = 0;
            p_de = 0; p_vb = 0; line_idx = 0; run = 0; nlines = 0; lastw = 0;
            pend = 0; pend_w = 0; pend_h = 0;
            {e_r, e_g, e_b} = 24'd0;
            e_de = 0; e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0; e_ce = 0; e_stb = 0;
            e_aw = 0; e_ah = 0;
        end else begin
            e_ce  = vid.ce_pix;
            e_stb = 0;
            if (vid.ce_pix) begin
                // the pixel accepted on the previous qualified edge leaves now
                {e_r, e_g, e_b} = h_de ? pixel(h_v, h_odd, vid.scanlines, vid.tint) : 24'd0;
                e_de = h_de; e_hs = h_hs; e_vs = h_vs; e_hb = h_hb; e_vb = h_vb;
                if (pend) begin
                    e_stb = 1; e_aw = pend_w; e_ah = pend_h; pend = 0;
                end
                xde   = ~vid.HBlank & ~vid.VBlank;
                h_v   = vid.video; h_de = xde; h_hs = vid.HSync; h_vs = vid.VSync;
                h_hb  = vid.HBlank; h_vb = vid.VBlank;
                h_odd = (line_idx % 2) == 1;
                if (p_de && !xde) begin
                    nlines = (nlines < SAT) ? nlines + 1 : SAT;
                    lastw  = run;
                    run    = 0;
                    if (!vid.VBlank) line_idx++;
                end else if (xde) begin
                    run = (run < SAT) ? run + 1 : SAT;
                end
                if (vid.VBlank) line_idx = 0;
                if (vid.VBlank && !p_vb) begin
                    pend = 1; pend_w = lastw; pend_h = nlines;
                    nlines = 0; lastw = 0;
                end
                p_de = xde;
                p_vb = vid.VBlank;
            end
        end
    end

    always @(negedge clk) begin
        chk("rgb", 64'({vid.r, vid.g, vid.b}), 64'({e_r, e_g, e_b}));
        chk("sync", 64'({vid.de, vid.hs_o, vid.vs_o, vid.hb_o, vid.vb_o, vid.ce_pix_o}),
            64'({e_de, e_hs, e_vs, e_hb, e_vb, e_ce}));
        chk("meas", 64'({vid.meas_stb, vid.act_width, vid.act_height}),
            64'({e_stb, CNT_W'(e_aw), CNT_W'(e_ah)}));
    end

    // ---------------- stimulus ----------------
    int   ce_mode = 0;
    bit   rnd_ctl = 0;
    logic ce_t = 0;

    task automatic pix(input logic [7:0] v, input logic hb, input logic vb,
                       input logic hs, input logic vs);
        vid.video = v; vid.HBlank = hb; vid.VBlank = vb;
        vid.HSync = hs; vid.VSync = vs;
        if (rnd_ctl && $urandom_range(0, 15) == 0) begin
            vid.scanlines = 2'($urandom_range(0, 3));
            vid.tint      = 2'($urandom_range(0, 3));
        end
        forever begin
            case (ce_mode)
                0: vid.ce_pix = 1'b1;
                1: begin ce_t = ~ce_t; vid.ce_pix = ce_t; end
                default: vid.ce_pix = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            if (vid.ce_pix) break;
        end
    endtask

    task automatic vbl(input int n, input bit rv);
        for (int j = 0; j < n; j++)
            pix(rv ? 8'($urandom) : 8'd0, 1'b1, 1'b1, 1'b0, j < 2);
    endtask

    task automatic hline(input int w, input int hbl, input logic [7:0] v, input bit rv);
        for (int j = 0; j < w; j++)
            pix(rv ? 8'($urandom) : v, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < hbl; j++)
            pix(rv ? 8'($urandom) : 8'd0, 1'b1, 1'b0, j >= 1 && j < 3, 1'b0);
    endtask

    task automatic frame(input int w, input int nl, input int hbl,
                         input logic [7:0] v, input bit rv, input bit tight);
        for (int l = 0; l < nl; l++)
            hline(w, (tight && l == nl - 1) ? 0 : hbl, v, rv);
        vbl(4, rv);
    endtask

    task automatic wait_de(input string nm, input logic val);
        bit ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (vid.de === val) ok = 1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL %s: timeout waiting for de=%0b", nm, val);
        end
    endtask

    task automatic expect_meas(input string nm, input int w, input int h);
        bit ok = 0;
        for (int i = 0; i < 40000 && !ok; i++) begin
            @(negedge clk);
            if (vid.meas_stb === 1'b1) ok = 1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL %s: timeout waiting for meas_stb", nm);
        end else begin
            chk({nm, "_w"}, 64'(vid.act_width), 64'(w));
            chk({nm, "_h"}, 64'(vid.act_height), 64'(h));
        end
    endtask

    initial begin
        reset = 1'b1;
        vid.ce_pix = 0; vid.video = 0; vid.HBlank = 0; vid.VBlank = 0;
        vid.HSync = 0; vid.VSync = 0; vid.scanlines = 0; vid.tint = 0;
        @(negedge clk);
        chk("reset_state", 64'({vid.r, vid.g, vid.b, vid.de, vid.meas_stb, vid.act_width}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // asynchronous reset in the middle of an active line
        ce_mode = 0;
        vbl(3, 0);
        repeat (5) pix(8'hC8, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1 chk("rst_async", 64'({vid.r, vid.g, vid.b, vid.de, vid.ce_pix_o}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pix(8'hC8, 0, 0, 0, 0);
        chk("first_de0", 64'(vid.de), 64'd0);
        pix(8'hC8, 0, 0, 0, 0);
        chk("first_de1", 64'(vid.de), 64'd1);
        hline(6, 3, 8'hC8, 0);
        vbl(4, 0);

        // grey, undimmed, ce_pix every other clock
        ce_mode = 1;
        fork
            frame(12, 3, 4, 8'hC8, 0, 0);
            begin
                wait_de("grey_on", 1'b1);
                chk("grey_px", 64'({vid.r, vid.g, vid.b}), 64'h00C8C8C8);
                wait_de("grey_off", 1'b0);
                chk("grey_blank", 64'({vid.r, vid.g, vid.b}), 64'd0);
            end
        join

        // amber with 50% scanlines: even line full, odd line halved
        ce_mode = 0;
        vid.scanlines = 2'd2;
        vid.tint = 2'd2;
        fork
            frame(10, 4, 3, 8'h80, 0, 0);
            begin
                wait_de("amb_l0", 1'b1);
                chk("amber_even", 64'({vid.r, vid.g, vid.b}), 64'h00806000);
                wait_de("amb_gap", 1'b0);
                wait_de("amb_l1", 1'b1);
                chk("amber_odd", 64'({vid.r, vid.g, vid.b}), 64'h00403000);
            end
        join

        // pixel clock stalled for 10 clks mid-line
        repeat (5) pix(8'($urandom), 0, 0, 0, 0);
        vid.ce_pix = 1'b0;
        repeat (10) @(negedge clk);
        hline(8, 3, 8'h55, 0);
        vbl(4, 0);

        // geometry measurement
        ce_mode = 2;
        fork frame(530, 3, 6, 8'h10, 1, 0); expect_meas("wide", 530, 3); join
        fork frame(8, 240, 3, 8'h10, 1, 0); expect_meas("ntsc", 8, 240); join
        fork frame(6, 301, 3, 8'h10, 1, 0); expect_meas("pal", 6, 301); join
        fork frame(17, 5, 3, 8'h10, 1, 1); expect_meas("tight", 17, 5); join
        fork
            begin
                repeat (3) pix(8'd0, 1, 0, 0, 0);
                vbl(4, 0);
            end
            expect_meas("empty", 0, 0);
        join

        // saturation followed by a normal frame
        ce_mode = 0;
        fork frame(3000, 1, 4, 8'h20, 0, 0); expect_meas("sat", SAT, 1); join
        fork frame(25, 2, 4, 8'h20, 0, 0); expect_meas("after_sat", 25, 2); join

        // randomised frames with live control changes
        ce_mode = 2;
        rnd_ctl = 1;
        repeat (25)
            frame(int'($urandom_range(1, 40)), int'($urandom_range(0, 10)),
                  int'($urandom_range(1, 6)), 8'd0, 1, bit'($urandom_range(0, 1)));
        rnd_ctl = 0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
